// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//
// Scans a 4x4 matrix keypad by pulling one row low at a time. It samples the
// pulled-up column inputs and debounces the result into a clean key code,
// a one-cycle press strobe and a held level.
//
// Ports
//   hwclk         in   system clock; the only clock in the block
//   rst           in   asynchronous, active-high reset
//   keypad_r      out  [3:0] row drive, active-low, one-cold
//   keypad_c_din  in   [3:0] raw column levels; 0 = pressed on the driven row
//   key_code      out  [3:0] debounced key index, row*4 + col; kept after release
//   key_valid     out  one-cycle strobe when a press is accepted
//   key_held      out  high from press acceptance until release acceptance
//   key_release   out  one-cycle strobe when a release is accepted
//                      (this port exists only when KEYPAD_RELEASE_EN is defined)
//
// Parameters
//   SCAN_DIV        hwclk cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical full scans to accept a change (>= 1)
//
// Optional feature macro: KEYPAD_RELEASE_EN adds the key_release strobe.
//
// Debounce FSM
//   state        | meaning
//   IDLE         | no key accepted, no candidate
//   PRESS_PEND   | candidate key seen on cnt consecutive scans
//   HELD         | key_code accepted and still present
//   RELEASE_PEND | held key missing on cnt consecutive scans

module keypad_scan_debounce #(
   parameter int SCAN_DIV       = 12000,
   parameter int DEBOUNCE_SCANS = 10
) (
   input  logic       hwclk,
   input  logic       rst,
   output logic [3:0] keypad_r,
   input  logic [3:0] keypad_c_din,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
`ifdef KEYPAD_RELEASE_EN
   ,
   output logic       key_release
`endif
);

   localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_PEND   = 2'd1,
      HELD         = 2'd2,
      RELEASE_PEND = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Column synchronizer. Resets to "nothing pressed".
   // ------------------------------------------------------------------
   logic [3:0] sync_a;
   logic [3:0] sync_b;

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         sync_a <= 4'hF;
         sync_b <= 4'hF;
      end else begin
         sync_a <= keypad_c_din;
         sync_b <= sync_a;
      end
   end

   // ------------------------------------------------------------------
   // Row drive and dwell timer
   // ------------------------------------------------------------------
   logic [1:0]         row_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               sample_now;

   assign sample_now = (dwell_q == DWELL_LAST);
   assign keypad_r   = ~(4'b0001 << row_q);

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         row_q   <= 2'd0;
         dwell_q <= '0;
      end else if (sample_now) begin
         row_q   <= row_q + 2'd1;   // 3 -> 0 wrap is the intended row order
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_q + DWELL_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Per-row column decode: lowest pressed column wins
   // ------------------------------------------------------------------
   logic       col_hit;
   logic [1:0] col_idx;

   always_comb begin
      col_hit = (sync_b != 4'hF);
      col_idx = 2'd0;
      if (!sync_b[0])      col_idx = 2'd0;
      else if (!sync_b[1]) col_idx = 2'd1;
      else if (!sync_b[2]) col_idx = 2'd2;
      else if (!sync_b[3]) col_idx = 2'd3;
   end

   // ------------------------------------------------------------------
   // Raw scan result. The first key found in row-major order is held until
   // row 3 is sampled, then published for one cycle with scan_done_q.
   // ------------------------------------------------------------------
   logic       found_q;
   logic [3:0] found_key_q;
   logic       scan_done_q;
   logic       raw_hit_q;
   logic [3:0] raw_key_q;

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         found_q     <= 1'b0;
         found_key_q <= 4'd0;
         scan_done_q <= 1'b0;
         raw_hit_q   <= 1'b0;
         raw_key_q   <= 4'd0;
      end else begin
         scan_done_q <= 1'b0;
         if (sample_now) begin
            if (row_q == 2'd3) begin
               scan_done_q <= 1'b1;
               raw_hit_q   <= found_q | col_hit;
               raw_key_q   <= found_q ? found_key_q : {row_q, col_idx};
               found_q     <= 1'b0;
            end else if (!found_q && col_hit) begin
               found_q     <= 1'b1;
               found_key_q <= {row_q, col_idx};
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Debounce FSM: state register
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             held_q, held_d;
   logic             raw_is_held;

   assign cnt_inc     = cnt_q + CNT_ONE;
   assign raw_is_held = raw_hit_q && (raw_key_q == code_q);

`ifdef KEYPAD_RELEASE_EN
   logic release_q, release_d;
`endif

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cand_q  <= 4'd0;
         cnt_q   <= '0;
         code_q  <= 4'd0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end
   end

`ifdef KEYPAD_RELEASE_EN
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         release_q <= 1'b0;
      end else begin
         release_q <= release_d;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Debounce FSM: next state, evaluated only on scan completion
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = 1'b0;
      held_d  = held_q;
`ifdef KEYPAD_RELEASE_EN
      release_d = 1'b0;
`endif

      if (scan_done_q) begin
         case (state_q)
            IDLE: begin
               if (raw_hit_q) begin
                  cand_d = raw_key_q;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d = HELD;
                     cnt_d   = '0;
                     code_d  = raw_key_q;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                  end else begin
                     state_d = PRESS_PEND;
                     cnt_d   = CNT_ONE;
                  end
               end
            end

            PRESS_PEND: begin
               if (!raw_hit_q) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (raw_key_q == cand_q) begin
                  if (cnt_inc == CNT_MAX) begin
                     state_d = HELD;
                     cnt_d   = '0;
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  // A different key restarts the count rather than resetting to IDLE.
                  cand_d = raw_key_q;
                  cnt_d  = CNT_ONE;
               end
            end

            HELD: begin
               // Any other scan result, including a different key, starts a release.
               if (!raw_is_held) begin
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     held_d  = 1'b0;
`ifdef KEYPAD_RELEASE_EN
                     release_d = 1'b1;
`endif
                  end else begin
                     state_d = RELEASE_PEND;
                     cnt_d   = CNT_ONE;
                  end
               end
            end

            RELEASE_PEND: begin
               if (raw_is_held) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_inc == CNT_MAX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  held_d  = 1'b0;
`ifdef KEYPAD_RELEASE_EN
                  release_d = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               held_d  = 1'b0;
            end
         endcase
      end
   end

   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;
`ifdef KEYPAD_RELEASE_EN
   assign key_release = release_q;
`endif

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
// cyc counts hwclk rising edges since reset release. Row r of scan k is
// sampled on edge 16*(k-1) + 4*(r+1), so scan k completes on edge 16*k.
// The FSM reacts one edge later, so an accepted press appears at edge 16*k+1.

module tb_keypad_scan_debounce;

   logic        hwclk = 1'b0;
   logic        rst   = 1'b1;
   logic [3:0]  keypad_r;
   logic [3:0]  keypad_c_din;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
`ifdef KEYPAD_RELEASE_EN
   logic        key_release;
`endif

   logic [15:0] keys = 16'h0000;

   int n_total = 0;
   int n_pass  = 0;
   int cyc;
   int n_valid = 0;
   int last_vcyc = -1;
   int n_rel = 0;
   int last_rcyc = -1;

   keypad_scan_debounce #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .hwclk        (hwclk),
      .rst          (rst),
      .keypad_r     (keypad_r),
      .keypad_c_din (keypad_c_din),
      .key_code     (key_code),
      .key_valid    (key_valid),
      .key_held     (key_held)
`ifdef KEYPAD_RELEASE_EN
      ,
      .key_release  (key_release)
`endif
   );

   always #5 hwclk = ~hwclk;

   // Keypad model: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      keypad_c_din = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4 + c] && !keypad_r[r]) keypad_c_din[c] = 1'b0;
   end

   always @(posedge hwclk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge hwclk) begin
      if (key_valid) begin
         n_valid   = n_valid + 1;
         last_vcyc = cyc;
      end
`ifdef KEYPAD_RELEASE_EN
      if (key_release) begin
         n_rel     = n_rel + 1;
         last_rcyc = cyc;
      end
`endif
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, act, exp, cyc);
   endtask

   task automatic tick();
      @(negedge hwclk);
      #1;
   endtask

   task automatic run_to(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 2000) begin
         tick();
         guard++;
      end
      chk("run_to", cyc, c);
   endtask

   task automatic clear_counts();
      n_valid   = 0;
      last_vcyc = -1;
      n_rel     = 0;
      last_rcyc = -1;
   endtask

   task automatic do_reset(input logic [15:0] k);
      rst  = 1'b1;
      keys = k;
      tick();
      tick();
      rst = 1'b0;
      clear_counts();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      // 1. Reset mid-scan, then the row sequence
      do_reset(16'h0000);
      run_to(10);
      rst = 1'b1;
      #1;
      chk("rst_row", keypad_r, 4'b1110);
      chk("rst_code", key_code, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
`ifdef KEYPAD_RELEASE_EN
      chk("rst_release", key_release, 0);
`endif
      tick();
      rst = 1'b0;
      clear_counts();
      for (int i = 0; i <= 16; i++) begin
         chk("row_seq", keypad_r, 15 & ~(1 << ((i / 4) % 4)));
         tick();
      end

      // 2. Clean press of key 5 from reset, 5. then its release
      do_reset(16'h0020);
      run_to(48);
      chk("press_early", n_valid, 0);
      chk("press_held_early", key_held, 0);
      run_to(49);
      chk("press_valid", key_valid, 1);
      chk("press_code", key_code, 5);
      chk("press_held", key_held, 1);
      tick();
      chk("press_pulse_width", key_valid, 0);
      run_to(64);
      chk("press_count", n_valid, 1);
      chk("held_while_down", key_held, 1);
      keys = 16'h0000;
      run_to(112);
      chk("release_not_yet", key_held, 1);
      run_to(113);
      chk("release_held_fall", key_held, 0);
      chk("release_code_kept", key_code, 5);
`ifdef KEYPAD_RELEASE_EN
      chk("release_strobe", key_release, 1);
      tick();
      chk("release_pulse_width", key_release, 0);
      chk("release_count", n_rel, 1);
      chk("release_cyc", last_rcyc, 113);
`endif
      run_to(140);
      chk("release_no_extra_valid", n_valid, 1);

      // 3. Bounce: present, absent, then steady from scan 3
      do_reset(16'h0020);
      run_to(16);
      keys = 16'h0000;
      run_to(32);
      keys = 16'h0020;
      run_to(80);
      chk("bounce_early", n_valid, 0);
      run_to(81);
      chk("bounce_valid", key_valid, 1);
      chk("bounce_code", key_code, 5);
      run_to(120);
      chk("bounce_count", n_valid, 1);

      // 4. Keys 9 and 2 together, then key 2 released while 9 stays
      do_reset(16'h0204);
      run_to(49);
      chk("multi_valid", key_valid, 1);
      chk("multi_code", key_code, 2);
      run_to(64);
      keys = 16'h0200;
      run_to(112);
      chk("multi_held_before", key_held, 1);
      run_to(113);
      chk("multi_release", key_held, 0);
      chk("multi_code_kept", key_code, 2);
`ifdef KEYPAD_RELEASE_EN
      chk("multi_release_strobe", key_release, 1);
`endif
      chk("multi_no_new_yet", n_valid, 1);
      run_to(160);
      chk("multi_new_early", n_valid, 1);
      run_to(161);
      chk("multi_new_valid", key_valid, 1);
      chk("multi_new_code", key_code, 9);
      chk("multi_new_held", key_held, 1);
      chk("multi_total", n_valid, 2);

      // 6. Reset while the press is pending with cnt=2
      do_reset(16'h0020);
      run_to(40);
      rst = 1'b1;
      #1;
      chk("pend_rst_valid", key_valid, 0);
      chk("pend_rst_held", key_held, 0);
      tick();
      tick();
      chk("pend_no_strobe", n_valid, 0);
      rst = 1'b0;
      clear_counts();
      run_to(48);
      chk("pend_after_early", n_valid, 0);
      run_to(49);
      chk("pend_after_valid", key_valid, 1);
      chk("pend_after_code", key_code, 5);
      chk("pend_after_cyc", last_vcyc, 49);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Scans a 4x4 matrix keypad by driving one row low at a time, samples the pulled-up column inputs, and debounces the result into a clean key code and a single-cycle press strobe. It sits directly upstream of the LED/button logic: that logic consumes `key_valid`/`key_code` instead of edge-triggering on a raw, bouncing column pin. Column pull-ups stay in the top level's SB_IO instances; this block receives the `D_IN_0` nets.

## Interface
- `SCAN_DIV`, default 12000: `hwclk` cycles each row is driven (1 ms at 12 MHz); must be ≥ 4.
- `DEBOUNCE_SCANS`, default 10: consecutive identical full scans needed to accept a press or release; must be ≥ 1.
- `hwclk` in 1: system clock, 12 MHz; only clock in the block.
- `rst` in 1: asynchronous, active-high reset.
- `keypad_r` out 4: row drive, active-low, one-cold.
- `keypad_c_din` in 4: raw column levels from SB_IO with pull-up; 0 means pressed on the driven row.
- `key_code` out 4: debounced key index, `row*4 + col`.
- `key_valid` out 1: one-cycle strobe when a press is accepted.
- `key_held` out 1: level, high from press acceptance until release acceptance.
- `key_release` out 1: one-cycle strobe when a release is accepted. Present only with `KEYPAD_RELEASE_EN`.

## Operation
- **Synchronizer:** `keypad_c_din` passes through a 2-flop synchronizer before any use.
- **Row drive:** row index 0→1→2→3→0. `keypad_r` = ~(1 << row).
- **Dwell counter:** counts 0..`SCAN_DIV`-1 for each row. On the last dwell cycle the synchronized columns are sampled for the current row, then the row advances.
- **Raw scan result:** during a scan, the first pressed key in row-major order (lowest row, then lowest column) is latched. When row 3 is sampled, the scan completes with raw = that key code, or NONE.
- **Multiple keys:** the lowest code wins.
- **Debounce FSM:** evaluated once per scan completion, using a candidate register `cand` and a counter `cnt`.
  - IDLE:
    - raw = NONE → stay.
    - raw = k → PRESS_PEND with `cand`=k, `cnt`=1; if `DEBOUNCE_SCANS`=1, accept immediately.
  - PRESS_PEND:
    - raw = `cand` → `cnt`+1.
    - `cnt` reaches `DEBOUNCE_SCANS` → HELD; `key_code`←`cand`; pulse `key_valid`; `key_held`←1.
    - raw = other key j → restart with `cand`=j, `cnt`=1.
    - raw = NONE → IDLE.
  - HELD:
    - raw = `key_code` → stay.
    - otherwise → RELEASE_PEND with `cnt`=1.
  - RELEASE_PEND:
    - raw ≠ `key_code` → `cnt`+1.
    - `cnt` reaches `DEBOUNCE_SCANS` → IDLE; `key_held`←0; pulse `key_release` if compiled in.
    - raw = `key_code` → HELD.
- **Changing keys:** a different key appearing while HELD counts as a release of the held key. The new key is only recognized by a later press sequence starting from IDLE.
- **Counter widths:** `cnt` width is $clog2(`DEBOUNCE_SCANS`+1); the dwell counter width is $clog2(`SCAN_DIV`). Neither counter wraps.
- **`key_code` retention:** `key_code` holds its last accepted value after release.

## Timing
- **Reset (async assert, sync release):**
  - `keypad_r`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, `key_release`=0.
  - State IDLE; row 0; dwell 0; `cnt`=0; synchronizer flops=4'b1111.
- **Reset mid-operation:** aborts any pending press or release; no strobe is emitted.
- **Scan period:** 4·`SCAN_DIV` cycles.
- **Column sample point:** `SCAN_DIV`-1 cycles after a row is driven. The synchronizer therefore sees ≥ 2 settled cycles.
- **Strobes:** `key_valid` and `key_release` are registered and assert the cycle after the scan-completing sample, for exactly 1 cycle.
- **`key_held`:** changes in the same cycle as the corresponding strobe.
- **Press latency:** `DEBOUNCE_SCANS` scan completions after the first scan that sees the key, plus 1 cycle. Worst case from a physical press: (`DEBOUNCE_SCANS`+1)·4·`SCAN_DIV`+3 cycles.
- **No handshake:** consumers must sample `key_valid` every cycle.

## Configuration
- `KEYPAD_RELEASE_EN` defined: the `key_release` port exists and pulses on accepted release.
- `KEYPAD_RELEASE_EN` undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3. The bench keypad model pulls the column low when its key's row is driven low.
1. **Reset:** assert `rst` mid-scan → immediately `keypad_r`=1110, `key_code`=0, `key_valid`=0, `key_held`=0; the row sequence after release is 1110, 1101, 1011, 0111, each held 4 cycles.
2. **Clean press:** hold key 5 (row 1, col 1) from reset → exactly one `key_valid` pulse with `key_code`=5, 1 cycle after the third scan completion (cycle 49); `key_held`=1 while held.
3. **Bounce:** key 5 present, absent, present, then steady → no strobe until 3 consecutive present scans; exactly one `key_valid` total.
4. **Simultaneous keys:** hold keys 9 and 2 → `key_code`=2, one pulse. Then release key 2 while 9 stays held → release accepted after 3 scans, then a new press of 9 after 3 more scans.
5. **Release:** release key 5 after acceptance → `key_held` falls exactly 3 scans later. With `KEYPAD_RELEASE_EN`, `key_release` pulses once in that same cycle; `key_code` stays 5.
6. **Reset during pending press:** assert `rst` during PRESS_PEND with `cnt`=2 → no `key_valid`. After release of `rst` with the key still held, `key_valid` arrives 3 full scans later.
